// File: rtl/coldata_i2c_master.sv
// Single-register I2C master: write, or register-pointer write plus repeated-START read; each bit spans 4 divider ticks.
// Latency: 29 bits (write) or 39 bits (read) x 4 x CLK_DIV cycles from start to done; start is ignored while busy.
module coldata_i2c_master #(
  parameter int CLK_DIV = 100
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
    RSTART, ADDR_R, ACK_AR, RDATA, NACK, STOP
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic [1:0]  phase;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        op_rw;
  logic [6:0]  op_dev;
  logic [7:0]  op_reg;
  logic [7:0]  op_wdat;
  logic        err;
  logic        sda_m, sda_s;
  logic        tick;
  logic        is_ack;
  logic        scl_nxt, sda_nxt;

  assign tick   = (state != IDLE) && (div == 16'(CLK_DIV - 1));
  assign is_ack = (state == ACK_A) || (state == ACK_R) || (state == ACK_D) || (state == ACK_AR);

  // START leaves SCL high on entry and STOP leaves it high on exit, so the bus never sees a stray edge.
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = 1'b0;
    if (state != IDLE) begin
      scl_nxt = ((phase == 2'd0) && (state != START)) || ((phase == 2'd3) && (state != STOP));
      case (state)
        START, RSTART:               sda_nxt = phase[1];
        ADDR_W, REG, WDATA, ADDR_R:  sda_nxt = ~shreg[7];
        STOP:                        sda_nxt = ~phase[1];
        default:                     sda_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      div     <= '0;
      phase   <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      op_rw   <= 1'b0;
      op_dev  <= '0;
      op_reg  <= '0;
      op_wdat <= '0;
      err     <= 1'b0;
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      rd_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      sda_m  <= sda_i;
      sda_s  <= sda_m;
      scl_oe <= scl_nxt;
      sda_oe <= sda_nxt;
      done   <= 1'b0;
      if (done) busy <= 1'b0;

      if (state == IDLE) begin
        div    <= '0;
        phase  <= '0;
        bitcnt <= '0;
        if (start && !busy) begin
          state   <= START;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          err     <= 1'b0;
          op_rw   <= rw;
          op_dev  <= dev_addr;
          op_reg  <= reg_addr;
          op_wdat <= wr_data;
        end
      end else if (!tick) begin
        div <= div + 16'd1;
      end else begin
        div   <= '0;
        phase <= phase + 2'd1;
        if (phase == 2'd2) begin
          if (is_ack && sda_s) err <= 1'b1;
          if (state == RDATA) shreg <= {shreg[6:0], sda_s};
        end else if (phase == 2'd3) begin
          case (state)
            START: begin
              state  <= ADDR_W;
              shreg  <= {op_dev, 1'b0};
              bitcnt <= '0;
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                case (state)
                  ADDR_W:  state <= ACK_A;
                  REG:     state <= ACK_R;
                  WDATA:   state <= ACK_D;
                  default: state <= ACK_AR;
                endcase
              end
            end
            ACK_A: begin
              state  <= err ? STOP : REG;
              shreg  <= op_reg;
              bitcnt <= '0;
            end
            ACK_R: begin
              if (err)        state <= STOP;
              else if (op_rw) state <= RSTART;
              else            state <= WDATA;
              shreg  <= op_wdat;
              bitcnt <= '0;
            end
            ACK_D:  state <= STOP;
            RSTART: begin
              state  <= ADDR_R;
              shreg  <= {op_dev, 1'b1};
              bitcnt <= '0;
            end
            ACK_AR: begin
              state  <= err ? STOP : RDATA;
              bitcnt <= '0;
            end
            RDATA: begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                state   <= NACK;
                rd_data <= shreg;
              end
            end
            NACK: state <= STOP;
            STOP: begin
              state   <= IDLE;
              done    <= 1'b1;
              ack_err <= err;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_coldata_i2c_master.sv
// Directed bench for coldata_i2c_master with a behavioural I2C slave at address 0x3C that records bus tokens.
module tb_coldata_i2c_master;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV = 7'h3C;
  localparam logic [11:0] T_START = 12'h200;
  localparam logic [11:0] T_STOP  = 12'h300;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic       sda_i;
  logic       slave_pull = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  assign sda_i = ~(sda_oe | slave_pull);

  coldata_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (done) done_cnt++;

  // Behavioural slave: acks its own address and every following byte, returns rd_val on a read.
  logic [7:0] rd_val = 8'h5A;
  logic       scl_p = 1'b1, sda_p = 1'b1, scl_n, sda_n;
  logic       in_xfer = 1'b0, tx = 1'b0, ack_seen = 1'b0;
  logic [7:0] sh = '0, txb = '0;
  int         cnt = 0, byte_no = 0;

  always @(negedge ACLK) begin
    scl_n = ~scl_oe;
    sda_n = sda_i;
    if (scl_p && scl_n && sda_p && !sda_n) begin
      obs_q.push_back(T_START);
      in_xfer = 1'b1; cnt = 0; byte_no = 0; tx = 1'b0; slave_pull = 1'b0;
    end else if (scl_p && scl_n && !sda_p && sda_n && in_xfer) begin
      obs_q.push_back(T_STOP);
      in_xfer = 1'b0; slave_pull = 1'b0;
    end else if (in_xfer && !scl_p && scl_n) begin
      if (cnt < 8) begin
        sh = {sh[6:0], sda_n};
        cnt++;
      end else if (cnt == 8) begin
        obs_q.push_back({3'b000, sda_n, sh});
        ack_seen = !sda_n;
        cnt = 9;
      end
    end else if (in_xfer && scl_p && !scl_n) begin
      if (cnt == 8) begin
        slave_pull = tx ? 1'b0 : ((byte_no == 0) ? (sh[7:1] == SLV) : 1'b1);
      end else if (cnt == 9) begin
        cnt = 0;
        if (byte_no == 0 && sh[0] && ack_seen) begin
          tx = 1'b1; txb = rd_val; slave_pull = ~txb[7];
        end else begin
          tx = 1'b0; slave_pull = 1'b0;
        end
        byte_no++;
      end else if (tx && cnt > 0) begin
        slave_pull = ~txb[7-cnt];
      end
    end
    scl_p = scl_n;
    sda_p = sda_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge ACLK);
    rw = r; dev_addr = d; reg_addr = ra; wr_data = wd; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic drain(input string tag);
    logic [11:0] o, e;
    repeat (20) @(negedge ACLK);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      chk(tag, o, e);
    end
    chk({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_write(input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
    exp_q.push_back(T_START);
    exp_q.push_back({4'h0, d, 1'b0});
    exp_q.push_back({4'h0, ra});
    exp_q.push_back({4'h0, wd});
    exp_q.push_back(T_STOP);
  endtask

  initial begin
    int c, d0;

    repeat (3) @(negedge ACLK);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);

    // Plain write
    push_write(7'h3C, 8'h12, 8'hA5);
    pulse(1'b0, 7'h3C, 8'h12, 8'hA5);
    chk("wr_busy_after_start", busy, 1'b1);
    wait_done(c);
    chk("wr_latency_in_range", (c >= 29*16 && c <= 29*16+2), 1'b1);
    chk("wr_ack_err", ack_err, 1'b0);
    chk("wr_rd_data_kept", rd_data, 8'h00);
    chk("wr_busy_in_done", busy, 1'b1);
    @(negedge ACLK);
    chk("wr_busy_after_done", busy, 1'b0);
    chk("wr_done_one_cycle", done, 1'b0);
    drain("wr_bus");

    // Register read with repeated START, master NACKs the data byte
    exp_q.push_back(T_START);
    exp_q.push_back(12'h078);
    exp_q.push_back(12'h007);
    exp_q.push_back(T_START);
    exp_q.push_back(12'h079);
    exp_q.push_back(12'h15A);
    exp_q.push_back(T_STOP);
    pulse(1'b1, 7'h3C, 8'h07, 8'h00);
    wait_done(c);
    chk("rd_latency_in_range", (c >= 39*16 && c <= 39*16+2), 1'b1);
    chk("rd_data", rd_data, 8'h5A);
    chk("rd_ack_err", ack_err, 1'b0);
    drain("rd_bus");

    // No slave at the address: abort straight to STOP
    exp_q.push_back(T_START);
    exp_q.push_back(12'h144);
    exp_q.push_back(T_STOP);
    pulse(1'b0, 7'h22, 8'h01, 8'h33);
    wait_done(c);
    chk("nack_latency_in_range", (c >= 11*16 && c <= 11*16+2), 1'b1);
    chk("nack_ack_err", ack_err, 1'b1);
    chk("nack_rd_data_kept", rd_data, 8'h5A);
    drain("nack_bus");

    // Second start while busy must be ignored
    d0 = done_cnt;
    push_write(7'h3C, 8'h12, 8'hA5);
    pulse(1'b0, 7'h3C, 8'h12, 8'hA5);
    chk("ign_ack_err_cleared", ack_err, 1'b0);
    repeat (100) @(negedge ACLK);
    pulse(1'b1, 7'h11, 8'hEE, 8'h0F);
    wait_done(c);
    chk("ign_latency_in_range", (c + 102 >= 29*16 && c + 102 <= 29*16+2), 1'b1);
    drain("ign_bus");
    chk("ign_single_done", done_cnt - d0, 1);
    chk("ign_ack_err", ack_err, 1'b0);
    chk("ign_rd_data_kept", rd_data, 8'h5A);

    // Reset during REG bit 3 (SCL low), then a clean write
    exp_q.push_back(T_START);
    exp_q.push_back(12'h078);
    pulse(1'b0, 7'h3C, 8'h12, 8'hA5);
    repeat (209) @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_scl_oe", scl_oe, 1'b0);
    chk("mid_rst_sda_oe", sda_oe, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    repeat (4) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    push_write(7'h3C, 8'h55, 8'hC3);
    pulse(1'b0, 7'h3C, 8'h55, 8'hC3);
    wait_done(c);
    chk("post_rst_latency_in_range", (c >= 29*16 && c <= 29*16+2), 1'b1);
    chk("post_rst_ack_err", ack_err, 1'b0);
    drain("post_rst_bus");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
